// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel, W-bit valid/ready stream multiplexer with a
// single registered output stage. Channel choice is either an explicit
// select (mode=0) or round-robin over the valid inputs (mode=1).
module stream_mux_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    // Highest legal channel index and the channel count, widened by one bit
    // so an out-of-range select can be detected without truncation.
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W + 1)'(CHANNELS);

    logic                out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]    out_data_reg,  out_data_next;
    logic [SEL_W-1:0]    out_chan_reg,  out_chan_next;
    logic [SEL_W-1:0]    ptr_reg,       ptr_next;

    logic                load;
    logic                grant_ok;
    logic                xfer;
    logic [SEL_W-1:0]    grant;
    logic [SEL_W-1:0]    rr_grant;
    logic                rr_found;
    logic [CHANNELS-1:0] upper_req;
    logic [CHANNELS-1:0] ready_vec;
    logic [WIDTH-1:0]    grant_data;
    logic [WIDTH-1:0]    chan_data [CHANNELS];

    // The output register can accept a word when empty or being drained.
    assign load = !out_valid_reg || out_ready;

    // Per-channel data slices, requests at/above the pointer, and the
    // one-hot ready vector (forced low while reset is held).
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign upper_req[gi]  = in_valid[gi] && (SEL_W'(gi) >= ptr_reg);
            assign ready_vec[gi]  = rst_n && load && grant_ok && (grant == SEL_W'(gi));
        end
    endgenerate

    // Round-robin pick: lowest valid channel at/above ptr, otherwise wrap to
    // the lowest valid channel overall.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(i);
            end
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                rr_grant = SEL_W'(i);
            end
        end
    end

    // Final grant: explicit select (may be out of range) or arbiter result.
    always_comb begin
        grant    = mode ? rr_grant : sel;
        grant_ok = mode ? rr_found : ({1'b0, sel} < NUM_CH);
    end

    // Word of the granted channel; zero when the grant is out of range.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = chan_data[i];
            end
        end
    end

    assign in_ready = ready_vec;
    assign xfer     = |(ready_vec & in_valid);

    // Next state: refill or drain the output register, advance the pointer
    // past the served channel on round-robin transfers.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_chan_next  = out_chan_reg;
        ptr_next       = ptr_reg;
        if (load) begin
            out_valid_next = xfer;
        end
        if (xfer) begin
            out_data_next = grant_data;
            out_chan_next = grant;
            if (mode) begin
                ptr_next = (grant == LAST_CH) ? '0 : grant + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            ptr_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_chan_reg  <= out_chan_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, W-bit streaming multiplexer with one registered output stage and valid/ready handshakes on every port. It is the successor to the team's 2:1 combinational select mux. It adds a channel count and a data width, back-pressure, and a second selection mode: round-robin arbitration over all valid inputs alongside the existing explicit select. It sits between several producer streams and a single consumer.

## Interface
- `WIDTH`, default 8: data width per channel (≥1).
- `CHANNELS`, default 4: number of input channels (≥2).
- `SEL_W`, default `$clog2(CHANNELS)`: width of the select and channel-ID fields. Derived; do not override.
- Reset is synchronous and active-low.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mode` in 1: 0 = explicit select via `sel`; 1 = round-robin arbitration.
- `sel` in SEL_W: selected channel when `mode`=0.
- `in_valid` in CHANNELS: bit i set means channel i holds a word.
- `in_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` out CHANNELS: bit i set means channel i's word is accepted this cycle.
- `out_valid` out 1: output register holds a word.
- `out_data` out WIDTH: registered output word.
- `out_chan` out SEL_W: source channel of `out_data`.
- `out_ready` in 1: consumer accepts the output word this cycle.

## Operation
- **Load enable.** `load = !out_valid || out_ready`. The output register is either empty or being drained this cycle.
- **Grant in mode 0.**
  - g = `sel`, grant_ok = (`sel` < CHANNELS).
  - An out-of-range `sel` grants nothing.
- **Grant in mode 1.**
  - Scan from pointer `ptr` upward, wrapping at CHANNELS-1 → 0.
  - g = first i with `in_valid[i]`=1; grant_ok = any `in_valid`.
- **Ready.** `in_ready[i] = load && grant_ok && (g == i)`. At most one bit is set. `in_ready` is never set for a non-granted channel.
  - In mode 0, `in_ready[sel]` may be high while `in_valid[sel]`=0. No transfer occurs in that case.
- **Transfer.** A transfer occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data` ← channel g's word.
  - `out_chan` ← g.
  - `out_valid` ← 1.
- **Drain with no refill.** If `load`=1 and no transfer occurs, `out_valid` ← 0. `out_data` and `out_chan` hold their last values.
- **Hold.** If `out_valid`=1 and `out_ready`=0:
  - `out_data` and `out_chan` are stable.
  - `out_valid` stays 1.
  - All `in_ready` bits are 0.
- **Pointer.**
  - On each transfer in mode 1, `ptr` ← (g+1) mod CHANNELS.
  - `ptr` is unchanged in mode 0 and on cycles without a transfer.
- **Mode and select changes.** Changes to `mode` or `sel` take effect on the next arbitration cycle. The word already in the output register is never lost or duplicated.

## Timing
- **Reset values** (while `rst_n`=0 at an edge):
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0.
  - `in_ready`=0 throughout reset.
  - Reset overrides any transfer in the same cycle.
  - Reset asserted mid-stream discards the held word.
- **Latency.** 1 cycle from input transfer to `out_valid`.
- **Throughput.** One word per cycle while `out_ready`=1.
- **Combinational path.** `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `in_valid` and `ptr`. No path runs from `in_ready` back to any input.
- **Output path.** `out_valid`, `out_data` and `out_chan` are driven directly from flops.
- **Wrap-around.** For non-power-of-2 CHANNELS, `ptr` wraps from CHANNELS-1 to 0 and never takes a value ≥ CHANNELS.

## Test plan
1. **Reset and first word.** CHANNELS=4, WIDTH=8.
   - Hold `rst_n`=0 for 2 cycles with all `in_valid`=1111 → `in_ready`=0000, `out_valid`=0, `out_data`=0x00.
   - Release with `mode`=0, `sel`=2, ch2=0xA5, `out_ready`=1 → `in_ready`=0100; next cycle `out_valid`=1, `out_data`=0xA5, `out_chan`=2.
2. **Back-pressure.**
   - With 0xA5 held, drive `out_ready`=0 for 3 cycles → `in_ready`=0000 and `out_data` stays 0xA5.
   - Raise `out_ready` with ch2 supplying 0x01, 0x02 → one new word per cycle, no loss or duplication.
3. **Round-robin.** `mode`=1, `out_ready`=1.
   - All channels valid → `out_chan` sequence 0,1,2,3,0,1.
   - Only ch1 and ch3 valid → 1,3,1,3.
   - A newly valid ch0 after a ch3 grant is served next.
4. **Non-power-of-2 and out-of-range.** CHANNELS=3.
   - `mode`=0, `sel`=3 → `in_ready`=000, output drains to `out_valid`=0.
   - `mode`=1 with all channels valid → `out_chan` sequence 0,1,2,0 (`ptr` never reaches 3).
5. **Mode switch mid-stream.**
   - `mode`=1 streaming; switch to `mode`=0, `sel`=1 on the cycle ch0 transfers → ch0's word appears once, and subsequent words come only from ch1.
6. **Reset mid-operation.**
   - Assert `rst_n`=0 while `out_valid`=1, `out_ready`=0 → next edge `out_valid`=0, `out_chan`=0.
   - After release in `mode`=1 with all channels valid → first grant is ch0.
